// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and the future transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        UART_RX_IDLE,
        UART_RX_START,
        UART_RX_DATA,
        UART_RX_PARITY,
        UART_RX_STOP
    } uart_rx_state_e;

    localparam logic [1:0] UART_PAR_NONE = 2'b00;
    localparam logic [1:0] UART_PAR_EVEN = 2'b01;
    localparam logic [1:0] UART_PAR_ODD  = 2'b10;

    localparam int unsigned UART_MIN_DATA_BITS = 5;
    localparam int unsigned UART_DEFAULT_OSR   = 16;

    // Clamp a requested data length into [UART_MIN_DATA_BITS, max_bits].
    function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                   input int unsigned max_bits);
        int unsigned r;
        r = 32'(req);
        if (r < UART_MIN_DATA_BITS) return 4'(UART_MIN_DATA_BITS);
        if (r > max_bits) return 4'(max_bits);
        return req;
    endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversample tick generator: clock divider plus bit-phase counter, with the
// three mid-bit sample strobes. clr_i restarts both counters from zero.
module uart_os_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned OSR   = UART_DEFAULT_OSR,
    parameter int unsigned DIV_W = 16,
    localparam int unsigned PH_W = $clog2(OSR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             os_tick_o,
    output logic [PH_W-1:0]  phase_o,
    output logic             samp_o,
    output logic             vote_o
);

    localparam logic [PH_W-1:0] PhSampA = PH_W'(OSR / 2 - 1);
    localparam logic [PH_W-1:0] PhSampB = PH_W'(OSR / 2);
    localparam logic [PH_W-1:0] PhVote  = PH_W'(OSR / 2 + 1);
    localparam logic [PH_W-1:0] PhLast  = PH_W'(OSR - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d, div_last;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             tick;

    // A divisor of 0 behaves like 1 (tick every cycle).
    assign div_last = (div_i == '0) ? '0 : div_i - DIV_W'(1);
    // >= keeps the divider sane if the divisor shrinks mid-count.
    assign tick     = !clr_i && (div_cnt_q >= div_last);

    // Next-state for divider and phase counters.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        phase_d   = phase_q;
        if (clr_i) begin
            div_cnt_d = '0;
            phase_d   = '0;
        end else if (tick) begin
            div_cnt_d = '0;
            phase_d   = (phase_q == PhLast) ? '0 : phase_q + PH_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            phase_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
        end
    end

    // Strobes refer to the phase carried by the current tick.
    assign os_tick_o = tick;
    assign phase_o   = phase_q;
    assign samp_o    = tick && ((phase_q == PhSampA) || (phase_q == PhSampB) ||
                                (phase_q == PhVote));
    assign vote_o    = tick && (phase_q == PhVote);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with runtime frame format, majority voting,
// false-start rejection and a valid/ready holding register.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W_MAX = 9,
    parameter int unsigned OSR        = UART_DEFAULT_OSR,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    input  logic [DIV_W-1:0]      i_baud_div,
    input  logic [3:0]            i_data_bits,
    input  logic [1:0]            i_parity,
    input  logic                  i_stop2,
    output logic [DATA_W_MAX-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_frame_err,
    output logic                  o_parity_err,
    output logic                  o_overrun,
    output logic                  o_break,
    output logic                  o_busy
);

    localparam int unsigned     PH_W   = $clog2(OSR);
    localparam logic [PH_W-1:0] PhLast = PH_W'(OSR - 1);

    uart_rx_state_e        state_q, state_d;
    logic                  rx_meta_q, rx_s_q, rx_prev_q;
    logic [3:0]            nbits_q, nbits_d, bit_cnt_q, bit_cnt_d;
    logic [1:0]            par_q, par_d, samp_q, samp_d;
    logic                  stop2_q, stop2_d, stop_cnt_q, stop_cnt_d;
    logic                  par_bit_q, par_bit_d, fe_q, fe_d;
    logic [DATA_W_MAX-1:0] data_q, data_d, out_data_q, out_data_d;
    logic                  valid_q, valid_d, out_fe_q, out_fe_d, out_pe_q, out_pe_d;
    logic                  overrun_q, overrun_d;
    logic                  os_tick, samp_tick, vote_tick, bit_end, fall, clr;
    logic                  vote, par_en, pe_now;
    logic [PH_W-1:0]       phase;

    assign fall    = rx_prev_q && !rx_s_q;
    assign clr     = (state_q == UART_RX_IDLE) && fall;
    assign bit_end = os_tick && (phase == PhLast);
    // Majority of the two stored samples and the live third one.
    assign vote    = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s_q) | (samp_q[0] & rx_s_q);
    assign par_en  = (par_q == UART_PAR_EVEN) || (par_q == UART_PAR_ODD);
    assign pe_now  = par_en && ((^data_q ^ par_bit_q) != (par_q == UART_PAR_ODD));

    uart_os_tick_gen #(
        .OSR   (OSR),
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr),
        .div_i     (i_baud_div),
        .os_tick_o (os_tick),
        .phase_o   (phase),
        .samp_o    (samp_tick),
        .vote_o    (vote_tick)
    );

`ifdef UART_RX_BREAK_DET_EN
    logic break_q, break_d;
`endif

    // Two-flop synchroniser plus previous-sample flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Frame FSM, sampling, and holding-register next-state.
    always_comb begin
        state_d    = state_q;
        nbits_d    = nbits_q;
        par_d      = par_q;
        stop2_d    = stop2_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        data_d     = data_q;
        par_bit_d  = par_bit_q;
        fe_d       = fe_q;
        samp_d     = samp_q;
        out_data_d = out_data_q;
        out_fe_d   = out_fe_q;
        out_pe_d   = out_pe_q;
        valid_d    = valid_q;
        overrun_d  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        break_d    = 1'b0;
`endif

        if (valid_q && i_ready) valid_d = 1'b0;
        if (samp_tick && !vote_tick) samp_d = {samp_q[0], rx_s_q};

        unique case (state_q)
            UART_RX_IDLE: begin
                if (fall) begin
                    state_d    = UART_RX_START;
                    nbits_d    = clamp_data_bits(i_data_bits, DATA_W_MAX);
                    par_d      = i_parity;
                    stop2_d    = i_stop2;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    data_d     = '0;
                    par_bit_d  = 1'b0;
                    fe_d       = 1'b0;
                end
            end
            UART_RX_START: begin
                if (vote_tick && vote) state_d = UART_RX_IDLE;
                else if (bit_end)      state_d = UART_RX_DATA;
            end
            UART_RX_DATA: begin
                if (vote_tick) begin
                    data_d[bit_cnt_q] = vote;
                    bit_cnt_d         = bit_cnt_q + 4'd1;
                end
                if (bit_end && (bit_cnt_q == nbits_q)) begin
                    state_d = par_en ? UART_RX_PARITY : UART_RX_STOP;
                end
            end
            UART_RX_PARITY: begin
                if (vote_tick) par_bit_d = vote;
                if (bit_end)   state_d   = UART_RX_STOP;
            end
            UART_RX_STOP: begin
                if (vote_tick) begin
`ifdef UART_RX_BREAK_DET_EN
                    if (!stop_cnt_q && !vote && (data_q == '0) && !(par_en && par_bit_q)) begin
                        break_d = 1'b1;
                        state_d = UART_RX_IDLE;
                    end else
`endif
                    if (stop_cnt_q == stop2_q) begin
                        // Deliver on the last stop vote; the remaining half bit is resync margin.
                        state_d = UART_RX_IDLE;
                        if (!valid_q || i_ready) begin
                            out_data_d = data_q;
                            out_fe_d   = fe_q | !vote;
                            out_pe_d   = pe_now;
                            valid_d    = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        fe_d       = fe_q | !vote;
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = UART_RX_IDLE;
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= UART_RX_IDLE;
            nbits_q    <= 4'(UART_MIN_DATA_BITS);
            par_q      <= UART_PAR_NONE;
            stop2_q    <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            data_q     <= '0;
            par_bit_q  <= 1'b0;
            fe_q       <= 1'b0;
            samp_q     <= '0;
            out_data_q <= '0;
            out_fe_q   <= 1'b0;
            out_pe_q   <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            nbits_q    <= nbits_d;
            par_q      <= par_d;
            stop2_q    <= stop2_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            data_q     <= data_d;
            par_bit_q  <= par_bit_d;
            fe_q       <= fe_d;
            samp_q     <= samp_d;
            out_data_q <= out_data_d;
            out_fe_q   <= out_fe_d;
            out_pe_q   <= out_pe_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    // Break pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) break_q <= 1'b0;
        else        break_q <= break_d;
    end
    assign o_break = break_q;
`else
    assign o_break = 1'b0;
`endif

    assign o_data       = out_data_q;
    assign o_valid      = valid_q;
    assign o_frame_err  = out_fe_q;
    assign o_parity_err = out_pe_q;
    assign o_overrun    = overrun_q;
    assign o_busy       = (state_q != UART_RX_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at baud_div 27, OSR 16 (432 clk per bit).
module tb_uart_rx_os;

    localparam int BIT = 432;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic [15:0] i_baud_div;
    logic [3:0]  i_data_bits;
    logic [1:0]  i_parity;
    logic        i_stop2;
    logic [8:0]  o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_frame_err;
    logic        o_parity_err;
    logic        o_overrun;
    logic        o_break;
    logic        o_busy;

    int tests = 0;
    int fails = 0;

    // Observation counters, sampled on the falling edge.
    int         acc_cnt = 0;
    int         vcyc    = 0;
    int         ovr_cnt = 0;
    int         brk_cnt = 0;
    logic [8:0] acc_data = '0;
    logic       acc_fe   = 1'b0;
    logic       acc_pe   = 1'b0;

    int a0, v0, o0, b0;

    always #5 clk = ~clk;

    uart_rx_os dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .i_baud_div   (i_baud_div),
        .i_data_bits  (i_data_bits),
        .i_parity     (i_parity),
        .i_stop2      (i_stop2),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err),
        .o_overrun    (o_overrun),
        .o_break      (o_break),
        .o_busy       (o_busy)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid && i_ready) begin
                acc_cnt  <= acc_cnt + 1;
                acc_data <= o_data;
                acc_fe   <= o_frame_err;
                acc_pe   <= o_parity_err;
            end
            if (o_valid)   vcyc    <= vcyc + 1;
            if (o_overrun) ovr_cnt <= ovr_cnt + 1;
            if (o_break)   brk_cnt <= brk_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Hold rx at b for n clocks; always returns 1ns after a rising edge.
    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [8:0] data, input int nbits, input logic par_en,
                              input logic par_bit, input int nstop, input logic last_stop,
                              input int gap);
        drive_bit(1'b0, BIT);
        for (int i = 0; i < nbits; i++) drive_bit(data[i], BIT);
        if (par_en) drive_bit(par_bit, BIT);
        for (int s = 0; s < nstop; s++) drive_bit((s == nstop - 1) ? last_stop : 1'b1, BIT);
        if (gap > 0) drive_bit(1'b1, gap * BIT);
    endtask

    task automatic snap();
        a0 = acc_cnt;
        v0 = vcyc;
        o0 = ovr_cnt;
        b0 = brk_cnt;
    endtask

    initial begin
        rst_n       = 1'b0;
        rx          = 1'b1;
        i_baud_div  = 16'd27;
        i_data_bits = 4'd8;
        i_parity    = 2'b00;
        i_stop2     = 1'b0;
        i_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_data", 32'(o_data), 32'h0);
        chk("rst_fe", 32'(o_frame_err), 32'h0);
        chk("rst_pe", 32'(o_parity_err), 32'h0);
        chk("rst_ovr", 32'(o_overrun), 32'h0);
        chk("rst_brk", 32'(o_break), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        rst_n = 1'b1;
        drive_bit(1'b1, 20);

        // 8N1 0xA5
        snap();
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, 1);
        chk("a5_acc", 32'(acc_cnt - a0), 32'd1);
        chk("a5_data", 32'(acc_data), 32'h0A5);
        chk("a5_fe", 32'(acc_fe), 32'h0);
        chk("a5_pe", 32'(acc_pe), 32'h0);
        chk("a5_vcyc", 32'(vcyc - v0), 32'd1);
        chk("a5_busy", 32'(o_busy), 32'h0);

        // 7E1 0x35 with wrong parity bit 1 (correct is 0)
        i_data_bits = 4'd7;
        i_parity    = 2'b01;
        snap();
        send_frame(9'h035, 7, 1'b1, 1'b1, 1, 1'b1, 1);
        chk("35_acc", 32'(acc_cnt - a0), 32'd1);
        chk("35_data", 32'(acc_data), 32'h035);
        chk("35_pe", 32'(acc_pe), 32'h1);
        chk("35_fe", 32'(acc_fe), 32'h0);

        // Glitch of 3 ticks, then 8N1 0x3C
        i_data_bits = 4'd8;
        i_parity    = 2'b00;
        snap();
        drive_bit(1'b0, 40);
        chk("gl_busy_hi", 32'(o_busy), 32'h1);
        drive_bit(1'b0, 41);
        drive_bit(1'b1, BIT);
        chk("gl_busy_lo", 32'(o_busy), 32'h0);
        chk("gl_noacc", 32'(vcyc - v0), 32'd0);
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1, 1'b1, 1);
        chk("3c_acc", 32'(acc_cnt - a0), 32'd1);
        chk("3c_data", 32'(acc_data), 32'h03C);
        chk("3c_fe", 32'(acc_fe), 32'h0);

        // Overrun: 0x11 then 0x22 back to back with consumer stalled
        i_ready = 1'b0;
        snap();
        send_frame(9'h011, 8, 1'b0, 1'b0, 1, 1'b1, 0);
        chk("ov_valid1", 32'(o_valid), 32'h1);
        chk("ov_data1", 32'(o_data), 32'h011);
        send_frame(9'h022, 8, 1'b0, 1'b0, 1, 1'b1, 1);
        chk("ov_data2", 32'(o_data), 32'h011);
        chk("ov_valid2", 32'(o_valid), 32'h1);
        chk("ov_pulse", 32'(ovr_cnt - o0), 32'd1);
        i_ready = 1'b1;
        drive_bit(1'b1, 3);
        chk("ov_drain", 32'(o_valid), 32'h0);
        chk("ov_acc", 32'(acc_cnt - a0), 32'd1);
        chk("ov_accdata", 32'(acc_data), 32'h011);

        // 8N2 with bad second stop, then clean 0x81
        i_stop2 = 1'b1;
        snap();
        send_frame(9'h07E, 8, 1'b0, 1'b0, 2, 1'b0, 1);
        chk("7e_data", 32'(acc_data), 32'h07E);
        chk("7e_fe", 32'(acc_fe), 32'h1);
        send_frame(9'h081, 8, 1'b0, 1'b0, 2, 1'b1, 1);
        chk("81_acc", 32'(acc_cnt - a0), 32'd2);
        chk("81_data", 32'(acc_data), 32'h081);
        chk("81_fe", 32'(acc_fe), 32'h0);

        // Break: 12 bit times low, 8N1
        i_stop2 = 1'b0;
        snap();
        drive_bit(1'b0, 12 * BIT);
        drive_bit(1'b1, BIT);
`ifdef UART_RX_BREAK_DET_EN
        chk("brk_pulse", 32'(brk_cnt - b0), 32'd1);
        chk("brk_novalid", 32'(vcyc - v0), 32'd0);
`else
        chk("brk_acc", 32'(acc_cnt - a0), 32'd1);
        chk("brk_data", 32'(acc_data), 32'h000);
        chk("brk_fe", 32'(acc_fe), 32'h1);
        chk("brk_nopulse", 32'(brk_cnt - b0), 32'd0);
`endif
        chk("brk_noovr", 32'(ovr_cnt - o0), 32'd0);
        snap();
        send_frame(9'h055, 8, 1'b0, 1'b0, 1, 1'b1, 1);
        chk("55_acc", 32'(acc_cnt - a0), 32'd1);
        chk("55_data", 32'(acc_data), 32'h055);
        chk("55_fe", 32'(acc_fe), 32'h0);

        // Data-length clamping: 15 -> 9 bits, 2 -> 5 bits
        i_data_bits = 4'd15;
        send_frame(9'h1A5, 9, 1'b0, 1'b0, 1, 1'b1, 1);
        chk("clamp9_data", 32'(acc_data), 32'h1A5);
        i_data_bits = 4'd2;
        send_frame(9'h015, 5, 1'b0, 1'b0, 1, 1'b1, 1);
        chk("clamp5_data", 32'(acc_data), 32'h015);
        chk("clamp5_fe", 32'(acc_fe), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised oversampling UART receiver and successor to the fixed 8-bit receiver. Features:
- Runtime data length, parity mode and stop-bit count.
- 2-flop input synchroniser and 3-sample majority voting.
- False-start rejection.
- valid/ready output holding register.
- Optional break detection.

It sits between the pad-side `rx` line and the RX FIFO or register-bank consumer.

## Interface
Parameters:
- `DATA_W_MAX`, 9: widest supported data field; `o_data` width.
- `OSR`, 16: oversample ticks per bit; even, ≥8.
- `DIV_W`, 16: width of `i_baud_div`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  asynchronous serial input; idle high.
- `i_baud_div`  in  DIV_W  clk cycles per oversample tick; 0 is treated as 1.
- `i_data_bits`  in  4  data bits per frame, 5..DATA_W_MAX; values outside the range clamp to the nearest bound.
- `i_parity`  in  2  parity mode: 00 none, 01 even, 10 odd, 11 none.
- `i_stop2`  in  1  1 = two stop bits checked.
- `o_data`  out  DATA_W_MAX  received word, LSB-aligned, upper bits zero.
- `o_valid`  out  1  `o_data` and the error flags are valid.
- `i_ready`  in  1  consumer accepts the word when `o_valid && i_ready`.
- `o_frame_err`  out  1  stop-bit error; travels with `o_data`.
- `o_parity_err`  out  1  parity mismatch; travels with `o_data`.
- `o_overrun`  out  1  one-cycle pulse: a completed frame was dropped.
- `o_break`  out  1  one-cycle pulse on break detection (macro only).
- `o_busy`  out  1  high in every state except IDLE.

Reset value of all outputs: 0.

## Operation
- `rx` passes through 2 flops (`rx_s`). All logic uses `rx_s`.
- Tick generator: divider counter wraps at `i_baud_div-1` and produces a 1-cycle `os_tick`. Phase counter runs 0..OSR-1 on `os_tick`.
- On entry to START, both counters are cleared.
- Each bit is sampled on phases OSR/2-1, OSR/2 and OSR/2+1. The bit value is the majority of the three samples.
- `i_data_bits`, `i_parity` and `i_stop2` are latched when leaving IDLE. Changes mid-frame have no effect on the current frame.

FSM:
- **IDLE**: leave only on a falling edge of `rx_s` (previous 1, current 0) → START. The line must be seen high before the receiver re-arms.
- **START**: voted bit = 1 → IDLE (false start, nothing reported). Voted bit = 0 → DATA at phase OSR-1.
- **DATA**: shift in LSB first for the latched bit count.
  - Then → PARITY if parity is enabled, else → STOP.
- **PARITY**: store the voted bit.
  - Even: the data XOR the parity bit must be 0.
  - Odd: the data XOR the parity bit must be 1.
- **STOP**: check the voted bit of each stop bit; any 0 sets the frame error.
  - After the vote of the last stop bit, do not wait for the bit end: deliver the frame and → IDLE. This gives a half-bit resync margin.

Delivery:
- `o_valid` = 0: load `o_data` and both error flags; set `o_valid`.
- `o_valid` = 1: drop the new frame; hold the old word and flags; pulse `o_overrun`.
- Handshake `o_valid && i_ready` clears `o_valid` next cycle. A delivery in the same cycle as the handshake is accepted (no overrun).

Reset mid-frame: FSM returns to IDLE and the holding register clears; no partial word is emitted.

## Timing
- Input to FSM latency: 2 clk (synchroniser).
- `o_valid` rises the clk after the `os_tick` carrying phase OSR/2+1 of the last stop bit.
- Bit period = OSR × max(`i_baud_div`,1) clk.
- `o_busy` falls in the same cycle `o_valid` rises.
- `o_overrun` and `o_break` are exactly 1 clk wide.
- Back-to-back frames with no idle gap are received without loss when the consumer keeps `i_ready` high.

## Configuration
`UART_RX_BREAK_DET_EN`

Defined:
- A frame whose data bits, parity bit (if enabled) and first stop bit all vote 0 is a break.
- On a break: pulse `o_break`; no `o_valid`; no overrun.
- The FSM waits in IDLE until `rx_s` = 1 before re-arming.

Undefined:
- `o_break` is tied 0.
- The same frame is delivered as data 0 with `o_frame_err` = 1. Parity error is set per the normal rule.

## Structure
Package `uart_pkg`:
- FSM state enum (`UART_RX_IDLE`, `UART_RX_START`, `UART_RX_DATA`, `UART_RX_PARITY`, `UART_RX_STOP`).
- Parity encoding constants (`UART_PAR_NONE`, `UART_PAR_EVEN`, `UART_PAR_ODD`).
- `UART_MIN_DATA_BITS` = 5.
- Default `OSR`.

Sub-module `uart_os_tick_gen`: clock divider, phase counter, clear input; outputs `os_tick`, phase and sample strobes. Shared with the future transmitter.

## Test plan
All scenarios: `i_baud_div`=27, `OSR`=16.
- 8N1, byte 0xA5, `i_ready`=1 → `o_data`=0x0A5, `o_valid` high 1 clk, both error flags 0.
- 7E1, data 0x35, parity bit driven 1 (wrong; correct is 0) → `o_data`=0x035, `o_parity_err`=1, `o_frame_err`=0.
- Idle line, 3-tick low glitch → no `o_valid`; `o_busy` high then returns 0; a following 0x3C frame is received correctly.
- Frames 0x11 then 0x22, `i_ready`=0 → `o_data` stays 0x011, one `o_overrun` pulse; assert `i_ready` → 0x011 consumed, `o_valid` falls.
- 8N2, second stop bit 0, data 0x7E → `o_data`=0x07E, `o_frame_err`=1; next frame 0x81 clean.
- `rx` low 12 bit times, then high:
  - macro defined → one `o_break` pulse, no `o_valid`.
  - macro undefined → `o_data`=0, `o_frame_err`=1.
  - Either way, a following frame 0x55 is received correctly.
